rv_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the immediate-format select consumed by the immediate generator, plus every datapath mux and write-enable. Handshakes with a single shared instruction/data memory port.

---
 rtl/rv_ctrl_pkg.sv | 64 ++++++
 rtl/rv_main_decoder.sv | 35 +++
 rtl/rv_multicycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_ctrl_pkg                                                          |
// | Shared encodings for the RV32I multi-cycle control path.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv_ctrl_pkg;

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_op     = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LUI    = 4'd1,
    CLS_AUIPC  = 4'd2,
    CLS_JAL    = 4'd3,
    CLS_JALR   = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_LOAD   = 4'd6,
    CLS_STORE  = 4'd7,
    CLS_OPIMM  = 4'd8,
    CLS_OP     = 4'd9
  } cls_t;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_u = 3'b011;
  localparam logic [2:0] c_imm_j = 3'b100;

  localparam logic [1:0] c_pc_plus4 = 2'b00;
  localparam logic [1:0] c_pc_imm   = 2'b01;
  localparam logic [1:0] c_pc_alu   = 2'b10;

  localparam logic [1:0] c_wb_alu = 2'b00;
  localparam logic [1:0] c_wb_mem = 2'b01;
  localparam logic [1:0] c_wb_pc4 = 2'b10;

  localparam logic [1:0] c_alua_rs1  = 2'b00;
  localparam logic [1:0] c_alua_pc   = 2'b01;
  localparam logic [1:0] c_alua_zero = 2'b10;

  localparam logic [3:0] c_alu_add = 4'b0000;
  localparam logic [3:0] c_alu_sub = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/rv_main_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_main_decoder                                                      |
// | Combinational opcode -> {class, immediate format, legal} mapping.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic [2:0] imm_sel,
  output logic       legal
);

  always_comb begin
    cls     = CLS_NONE;
    imm_sel = c_imm_i;
    legal   = 1'b1;
    case (opcode)
      c_op_lui:    begin cls = CLS_LUI;    imm_sel = c_imm_u; end
      c_op_auipc:  begin cls = CLS_AUIPC;  imm_sel = c_imm_u; end
      c_op_jal:    begin cls = CLS_JAL;    imm_sel = c_imm_j; end
      c_op_jalr:   begin cls = CLS_JALR;   imm_sel = c_imm_i; end
      c_op_branch: begin cls = CLS_BRANCH; imm_sel = c_imm_b; end
      c_op_load:   begin cls = CLS_LOAD;   imm_sel = c_imm_i; end
      c_op_store:  begin cls = CLS_STORE;  imm_sel = c_imm_s; end
      c_op_opimm:  begin cls = CLS_OPIMM;  imm_sel = c_imm_i; end
      c_op_op:     begin cls = CLS_OP;     imm_sel = c_imm_i; end
      default:     legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_multicycle_ctrl                                                   |
// | Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic [3:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       trap,
  output logic [2:0] state_o
);

  state_t     r_state;
  state_t     w_state_nxt;
  cls_t       r_cls;
  logic [2:0] r_imm_sel;

  cls_t       w_cls;
  logic [2:0] w_imm_sel;
  logic       w_legal;

  rv_main_decoder u_dec (
    .opcode  (opcode),
    .cls     (w_cls),
    .imm_sel (w_imm_sel),
    .legal   (w_legal)
  );

  // Class and immediate format are captured once per instruction, in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cls     <= CLS_NONE;
      r_imm_sel <= c_imm_i;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) begin
        r_cls     <= w_cls;
        r_imm_sel <= w_imm_sel;
      end
    end
  end

  assign state_o = r_state;

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = c_pc_plus4;
    reg_we      = 1'b0;
    wb_sel      = c_wb_alu;
    alu_a_sel   = c_alua_rs1;
    alu_b_sel   = 1'b0;
    alu_op      = c_alu_add;
    imm_sel     = c_imm_i;
    trap        = 1'b0;

    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        imm_sel = r_imm_sel;
        if (mem_ready) begin
          ir_we       = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        imm_sel     = r_imm_sel;
        w_state_nxt = w_legal ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        imm_sel   = r_imm_sel;
        alu_b_sel = !((r_cls == CLS_OP) || (r_cls == CLS_BRANCH));
        case (r_cls)
          CLS_LUI:             alu_a_sel = c_alua_zero;
          CLS_AUIPC, CLS_JAL:  alu_a_sel = c_alua_pc;
          default:             alu_a_sel = c_alua_rs1;
        endcase
        case (r_cls)
          CLS_OP:     alu_op = {funct7_5, funct3};
          // Only SRAI may set bit 30 on an immediate op; other funct3 reuse it as imm.
          CLS_OPIMM:  alu_op = {funct7_5 & (funct3 == 3'b101), funct3};
          CLS_BRANCH: alu_op = c_alu_sub;
          default:    alu_op = c_alu_add;
        endcase
        case (r_cls)
          CLS_BRANCH: begin
            pc_we       = 1'b1;
            pc_src      = br_taken ? c_pc_imm : c_pc_plus4;
            w_state_nxt = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: w_state_nxt = S_MEM;
          default:             w_state_nxt = S_WB;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (r_cls == CLS_STORE);
        imm_sel  = r_imm_sel;
        if (mem_ready) begin
          if (r_cls == CLS_STORE) begin
            pc_we       = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we      = 1'b1;
        pc_we       = 1'b1;
        imm_sel     = r_imm_sel;
        w_state_nxt = S_FETCH;
        case (r_cls)
          CLS_LOAD:           wb_sel = c_wb_mem;
          CLS_JAL, CLS_JALR:  wb_sel = c_wb_pc4;
          default:            wb_sel = c_wb_alu;
        endcase
        case (r_cls)
          CLS_JAL:  pc_src = c_pc_imm;
          CLS_JALR: pc_src = c_pc_alu;
          default:  pc_src = c_pc_plus4;
        endcase
      end

      S_TRAP: trap = 1'b1;

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_multicycle_ctrl                                                |
// | Scoreboard bench: directed instruction sequences, per-cycle outputs. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rv_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, alu_b_sel, trap;
  logic [1:0] pc_src, wb_sel, alu_a_sel;
  logic [3:0] alu_op;
  logic [2:0] imm_sel, state_o;

  rv_multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .imm_sel   (imm_sel),
    .trap      (trap),
    .state_o   (state_o)
  );

  typedef struct {
    string       nm;
    logic [23:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed order: state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
  // reg_we, wb_sel, alu_a_sel, alu_b_sel, alu_op, imm_sel, trap.
  function automatic logic [23:0] ev(input int st, rq, mw, as, iw, pw, ps,
                                     rw, ws, aa, ab, ao, im, tr);
    logic [23:0] v;
    v = {st[2:0], rq[0], mw[0], as[0], iw[0], pw[0], ps[1:0], rw[0],
         ws[1:0], aa[1:0], ab[0], ao[3:0], im[2:0], tr[0]};
    return v;
  endfunction

  logic [23:0] act;
  assign act = {state_o, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we,
                wb_sel, alu_a_sel, alu_b_sel, alu_op, imm_sel, trap};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t it;
      it = sb.pop_front();
      n_checks++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", it.nm, act, it.exp);
      end
    end
  end

  // Queue one cycle's expected outputs, then advance to just after the next rising edge.
  task automatic step(input string nm, input logic [23:0] e);
    sb.push_back('{nm: nm, exp: e});
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch, decode, exec and optionally writeback.
  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic bt, input int prev,
                           input logic [23:0] e_ex, input logic [23:0] e_wb,
                           input bit has_wb);
    opcode = op; funct3 = f3; funct7_5 = f7; br_taken = bt; mem_ready = 1'b1;
    step({nm, "_fetch"},  ev(1,1,0,0,1,0,0,0,0,0,0,0,prev,0));
    step({nm, "_decode"}, ev(2,0,0,0,0,0,0,0,0,0,0,0,prev,0));
    step({nm, "_exec"},   e_ex);
    if (has_wb) step({nm, "_wb"}, e_wb);
  endtask

  logic [23:0] z;

  initial begin
    z = ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; br_taken = 1'b0;
    @(posedge clk); #1;
    step("reset", z);
    step("reset_hold", z);
    rst_n = 1'b1;
    step("idle", z);

    run_instr("addi", 7'b0010011, 3'b000, 1'b0, 1'b0, 0,
              ev(3,0,0,0,0,0,0,0,0,0,1,0,0,0), ev(5,0,0,0,0,1,0,1,0,0,0,0,0,0), 1'b1);
    run_instr("srai", 7'b0010011, 3'b101, 1'b1, 1'b0, 0,
              ev(3,0,0,0,0,0,0,0,0,0,1,13,0,0), ev(5,0,0,0,0,1,0,1,0,0,0,0,0,0), 1'b1);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0,
              ev(3,0,0,0,0,0,0,0,0,0,1,0,0,0), ev(5,0,0,0,0,1,0,1,0,0,0,0,0,0), 1'b1);
    run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 0,
              ev(3,0,0,0,0,0,0,0,0,0,0,8,0,0), ev(5,0,0,0,0,1,0,1,0,0,0,0,0,0), 1'b1);

    // LW with two wait cycles on both the fetch and the data access.
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = 1'b0;
    step("lw_fetch_w1", ev(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    step("lw_fetch_w2", ev(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    step("lw_fetch",    ev(1,1,0,0,1,0,0,0,0,0,0,0,0,0));
    mem_ready = 1'b0;
    step("lw_decode",   ev(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("lw_exec",     ev(3,0,0,0,0,0,0,0,0,0,1,0,0,0));
    step("lw_mem_w1",   ev(4,1,0,1,0,0,0,0,0,0,0,0,0,0));
    step("lw_mem_w2",   ev(4,1,0,1,0,0,0,0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    step("lw_mem",      ev(4,1,0,1,0,0,0,0,0,0,0,0,0,0));
    step("lw_wb",       ev(5,0,0,0,0,1,0,1,1,0,0,0,0,0));

    run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 0,
              ev(3,0,0,0,0,1,1,0,0,0,0,8,2,0), z, 1'b0);
    run_instr("beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, 2,
              ev(3,0,0,0,0,1,0,0,0,0,0,8,2,0), z, 1'b0);
    run_instr("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0, 2,
              ev(3,0,0,0,0,0,0,0,0,0,1,0,0,0), ev(5,0,0,0,0,1,2,1,2,0,0,0,0,0), 1'b1);
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 0,
              ev(3,0,0,0,0,0,0,0,0,1,1,0,4,0), ev(5,0,0,0,0,1,1,1,2,0,0,0,4,0), 1'b1);
    run_instr("lui", 7'b0110111, 3'b000, 1'b0, 1'b0, 4,
              ev(3,0,0,0,0,0,0,0,0,2,1,0,3,0), ev(5,0,0,0,0,1,0,1,0,0,0,0,3,0), 1'b1);

    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 3,
              ev(3,0,0,0,0,0,0,0,0,0,1,0,1,0), z, 1'b0);
    step("sw_mem",      ev(4,1,1,1,0,1,0,0,0,0,0,0,1,0));

    // Second store: reset lands while MEM is still waiting on memory.
    run_instr("sw2", 7'b0100011, 3'b010, 1'b0, 1'b0, 1,
              ev(3,0,0,0,0,0,0,0,0,0,1,0,1,0), z, 1'b0);
    mem_ready = 1'b0;
    step("sw2_mem_w1",  ev(4,1,1,1,0,0,0,0,0,0,0,0,1,0));
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_async_mem_req: got %b expected 0", mem_req);
    end
    n_checks++;
    if (pc_we !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_async_pc_we: got %b expected 0", pc_we);
    end
    step("rst_async",   z);
    rst_n = 1'b1; mem_ready = 1'b1;
    step("rst_idle",    z);

    opcode = 7'b1111111; funct3 = 3'b000;
    step("ill_fetch",   ev(1,1,0,0,1,0,0,0,0,0,0,0,0,0));
    step("ill_decode",  ev(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      step("trap_hold", ev(6,0,0,0,0,0,0,0,0,0,0,0,0,1));

    n_checks++;
    if (trap !== 1'b1) begin
        n_fail++;
        $display("FAIL trap_sticky: got %b expected 1", trap);
    end
    n_checks++;
    if (mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL trap_no_req: got %b expected 0", mem_req);
    end
    n_checks++;
    if (state_o !== 3'd6) begin
        n_fail++;
        $display("FAIL trap_state: got %0d expected 6", state_o);
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
